mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have these parameters: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 16, max mem_req cycles without mem_ack (range 2..255).
REQ-002 SHALL have these ports, in this order:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
if_req  in  1  fetch request, held until if_valid.
if_addr  in  ADDR_W  fetch address.
if_valid  out  1  one-cycle fetch completion pulse.
if_rdata  out  DATA_W  fetched word, valid with if_valid.
d_req  in  1  data request, held until d_valid.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  store data.
d_valid  out  1  one-cycle data completion pulse.
d_rdata  out  DATA_W  load data, valid with d_valid.
err  out  1  completion was a timeout abort; qualifies if_valid/d_valid.
mem_req  out  1  memory access active.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_ack  in  1  memory completion, one cycle.
mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
busy  out  1  high when the FSM is not in IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY_I, BUSY_D; exactly one transaction in flight.
REQ-004 In IDLE, a port's request SHALL be eligible only if its req is high and its valid output is low that cycle (completing requester is not regranted).
REQ-005 IDLE with one eligible port SHALL move to that port's BUSY state at the next edge; no eligible port -> stay IDLE.
REQ-006 Both eligible SHALL resolve round-robin: the port not granted most recently wins; last-grant register resets to "data", so fetch wins the first tie.
REQ-007 On grant SHALL register addr, we (0 for fetch), and wdata (0 for fetch) into mem_addr/mem_we/mem_wdata, held stable until the transaction ends.
REQ-008 mem_req SHALL be high exactly while in BUSY_I or BUSY_D (registered; first high cycle is the cycle after the grant decision).
REQ-009 mem_ack sampled high in BUSY_x SHALL: return to IDLE, pulse x_valid for the next cycle, load x_rdata with mem_rdata (0 if store), err=0.
REQ-010 Minimum latency: req high at cycle N in IDLE, mem_ack at N+1 -> valid at N+2.
REQ-011 A cycle counter SHALL count BUSY cycles without mem_ack; if the TIMEOUT-th such cycle also lacks mem_ack, SHALL return to IDLE and pulse x_valid with err=1 and x_rdata=0.
REQ-012 mem_ack on the TIMEOUT-th cycle SHALL complete normally (ack beats timeout).
REQ-013 mem_ack while IDLE SHALL be ignored, with no output change.
REQ-014 if_valid and d_valid SHALL never be high together; err SHALL be 0 whenever both are low.
REQ-015 x_rdata SHALL hold its last value between pulses.
REQ-016 Requester input changes during BUSY SHALL not affect mem_* outputs.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 reset low SHALL immediately force IDLE, last-grant = data, counter = 0, and all outputs 0; an in-flight transaction is dropped without a valid pulse.
REQ-019 After reset rises, arbitration SHALL resume at the first rising edge with reset high.

Verification
REQ-020 Fetch: if_req=1, if_addr=0x100, mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0; if_valid at N+2; if_rdata=0xDEADBEEF; err=0.
REQ-021 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678, ack after 3 cycles -> mem_we=1, mem_wdata=0x12345678 held 3 cycles; d_valid; d_rdata=0.
REQ-022 Tie: if_req and d_req held high across 3 transactions -> grants fetch, data, fetch; valids never overlap.
REQ-023 Timeout: d_req load, mem_ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles, then d_valid=1, err=1, d_rdata=0; busy low after.
REQ-024 Ack on the 16th cycle -> normal completion, err=0.
REQ-025 Reset low mid-BUSY_I -> mem_req, busy, valids 0 immediately; no if_valid; after release, a held if_req is granted anew.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/data) arbiter onto a single memory port
//
// Arbitrates a fetch port and a data port onto one memory request port,
// one transaction in flight at a time, round-robin on ties, with a
// per-transaction timeout that completes the requester with err=1.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   if_req/if_addr      fetch request in; if_valid/if_rdata completion out
//   d_req/d_we/d_addr/d_wdata   data request in; d_valid/d_rdata completion out
//   err                 qualifies if_valid/d_valid: completion was a timeout
//   mem_req/mem_we/mem_addr/mem_wdata   memory request out
//   mem_ack/mem_rdata   memory completion in
//   busy                high whenever a transaction is in flight

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q;
  logic                last_d_q;   // 1 = data port was granted most recently
  logic [7:0]          cnt_q;      // BUSY cycles seen without mem_ack
  logic                if_valid_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic                d_valid_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                err_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  // A requester whose completion pulse is showing this cycle still holds
  // req high; masking it keeps it from being granted a second time.
  logic elig_i, elig_d, grant_i, grant_d, done;

  always_comb begin
    elig_i  = if_req && !if_valid_q;
    elig_d  = d_req  && !d_valid_q;
    grant_i = elig_i && (!elig_d || last_d_q);
    grant_d = elig_d && (!elig_i || !last_d_q);
    // Ack on the final allowed cycle wins over the timeout.
    done    = mem_ack || (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      cnt_q       <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q     <= BUSY_I;
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
          end else if (grant_d) begin
            state_q     <= BUSY_D;
            last_d_q    <= 1'b1;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            err_q     <= !mem_ack;
            if (state_q == BUSY_I) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_ack ? mem_rdata : '0;
            end else begin
              d_valid_q <= 1'b1;
              d_rdata_q <= (mem_ack && !mem_we_q) ? mem_rdata : '0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b1;

    // Fetch, minimum latency
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", {31'd0, mem_we}, 32'd0);
    chk("f_busy", {31'd0, busy}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("f_if_valid", {31'd0, if_valid}, 32'd1);
    chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_err", {31'd0, err}, 32'd0);
    chk("f_d_valid", {31'd0, d_valid}, 32'd0);
    chk("f_busy_after", {31'd0, busy}, 32'd0);
    mem_ack = 1'b0; if_req = 1'b0;
    step();
    chk("f_valid_pulse", {31'd0, if_valid}, 32'd0);
    chk("f_rdata_hold", if_rdata, 32'hDEADBEEF);

    // Ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'h55;
    step();
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
    chk("idle_ack_ivalid", {31'd0, if_valid}, 32'd0);
    chk("idle_ack_dvalid", {31'd0, d_valid}, 32'd0);
    chk("idle_ack_rdata", if_rdata, 32'hDEADBEEF);
    mem_ack = 1'b0;

    // Store, ack in third busy cycle, inputs change while busy
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    step();
    chk("s_mem_we", {31'd0, mem_we}, 32'd1);
    chk("s_mem_addr", mem_addr, 32'h40);
    chk("s_mem_wdata", mem_wdata, 32'h12345678);
    d_addr = 32'hFFF; d_wdata = 32'h0; d_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("s_hold_req", {31'd0, mem_req}, 32'd1);
      chk("s_hold_addr", mem_addr, 32'h40);
      chk("s_hold_wdata", mem_wdata, 32'h12345678);
      chk("s_hold_we", {31'd0, mem_we}, 32'd1);
      chk("s_no_valid", {31'd0, d_valid}, 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
    step();
    chk("s_d_valid", {31'd0, d_valid}, 32'd1);
    chk("s_d_rdata", d_rdata, 32'd0);
    chk("s_err", {31'd0, err}, 32'd0);
    mem_ack = 1'b0; d_req = 1'b0;
    step();

    // Tie: last grant is data, so fetch, data, fetch
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("tie_grant_addr", mem_addr, (t == 1) ? 32'h300 : 32'h200);
      chk("tie_mem_req", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h1111 * (t + 1);
      step();
      mem_ack = 1'b0;
      chk("tie_if_valid", {31'd0, if_valid}, (t == 1) ? 32'd0 : 32'd1);
      chk("tie_d_valid", {31'd0, d_valid}, (t == 1) ? 32'd1 : 32'd0);
      if (t == 1) chk("tie_d_rdata", d_rdata, 32'h2222);
      else        chk("tie_if_rdata", if_rdata, 32'h1111 * (t + 1));
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
    chk("tie_idle", {31'd0, busy}, 32'd0);

    // Timeout: load never acked
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    step();
    chk("to_first_req", {31'd0, mem_req}, 32'd1);
    for (int c = 2; c <= 16; c++) begin
      step();
      chk("to_req_held", {31'd0, mem_req}, 32'd1);
      chk("to_no_valid", {31'd0, d_valid}, 32'd0);
    end
    step();
    chk("to_d_valid", {31'd0, d_valid}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_mem_req", {31'd0, mem_req}, 32'd0);
    d_req = 1'b0;
    step();
    chk("to_err_clear", {31'd0, err}, 32'd0);

    // Ack on the 16th busy cycle completes normally
    d_req = 1'b1; d_addr = 32'h600;
    step();
    for (int c = 2; c <= 16; c++) step();
    chk("ack16_still_busy", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    step();
    mem_ack = 1'b0;
    chk("ack16_d_valid", {31'd0, d_valid}, 32'd1);
    chk("ack16_err", {31'd0, err}, 32'd0);
    chk("ack16_d_rdata", d_rdata, 32'hCAFE);
    d_req = 1'b0;
    step();

    // Reset mid-BUSY_I; both requests held, fetch must win again afterwards
    if_req = 1'b1; if_addr = 32'h700; d_req = 1'b1; d_addr = 32'h800;
    step();
    chk("r_pre_addr", mem_addr, 32'h700);
    #2 reset = 1'b0;
    #1;
    chk("r_mem_req", {31'd0, mem_req}, 32'd0);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_mem_addr", mem_addr, 32'd0);
    mem_ack = 1'b1;
    step();
    chk("r_no_if_valid", {31'd0, if_valid}, 32'd0);
    mem_ack = 1'b0;
    reset = 1'b1;
    step();
    chk("r_regrant_req", {31'd0, mem_req}, 32'd1);
    chk("r_regrant_addr", mem_addr, 32'h700);
    chk("r_if_valid_none", {31'd0, if_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h7777;
    step();
    mem_ack = 1'b0; if_req = 1'b0; d_req = 1'b0;
    chk("r_if_valid", {31'd0, if_valid}, 32'd1);
    chk("r_if_rdata", if_rdata, 32'h7777);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
